sipo_shift_reg_param: RTL and testbench

Parametrised serial-in/parallel-out shift register with framing, valid/ready output handshake and overflow detection. It extends our single-bit D flip-flop shift path to a configurable word width and shift order, and adds a registered parallel output stage. It sits between a serial bit source and any word-oriented consumer.

---
 rtl/sipo_shift_reg_param.sv | 129 ++++++++++++
 tb/tb_sipo_shift_reg_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_reg_param.sv
// Serial-in/parallel-out shift register with framing, a registered valid/ready
// output stage and sticky overflow. Optional even-parity frames via SIPO_PARITY_EN.
module sipo_shift_reg_param #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d,
   input  logic             d_valid,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic [CW-1:0]    bit_cnt,
   output logic             overflow,
   output logic             parity_err
);

   logic [WIDTH-1:0] sh, sh_nxt;
   logic [WIDTH-1:0] q_nxt, word;
   logic [CW-1:0]    cnt_nxt;
   logic             qv_nxt, ovf_nxt;
   logic             complete, out_free;

`ifdef SIPO_PARITY_EN
   typedef enum logic {COLLECT, PARITY} state_t;
   state_t state, state_nxt;
   logic   perr_r, perr_nxt;
   assign parity_err = perr_r;
`else
   assign parity_err = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
      if (MSB_FIRST) return {s[WIDTH-2:0], b};
      else           return {b, s[WIDTH-1:1]};
   endfunction

   always_comb begin
      sh_nxt   = sh;
      cnt_nxt  = bit_cnt;
      q_nxt    = q;
      qv_nxt   = q_valid;
      ovf_nxt  = overflow;
      complete = 1'b0;
      word     = sh;
`ifdef SIPO_PARITY_EN
      state_nxt = state;
      perr_nxt  = perr_r;
`endif
      // The output register can take a word if empty or being drained this cycle.
      out_free = !q_valid || q_ready;
      if (q_valid && q_ready) qv_nxt = 1'b0;

      if (clr) begin
         sh_nxt  = '0;
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
`ifdef SIPO_PARITY_EN
         state_nxt = COLLECT;
`endif
      end else if (d_valid) begin
`ifdef SIPO_PARITY_EN
         if (state == COLLECT) begin
            sh_nxt  = shift_in(sh, d);
            cnt_nxt = bit_cnt + CW'(1);
            if (bit_cnt == CW'(WIDTH - 1)) state_nxt = PARITY;
         end else begin
            complete  = 1'b1;
            word      = sh;
            cnt_nxt   = '0;
            state_nxt = COLLECT;
         end
`else
         sh_nxt = shift_in(sh, d);
         if (bit_cnt == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            word     = sh_nxt;
            cnt_nxt  = '0;
         end else begin
            cnt_nxt = bit_cnt + CW'(1);
         end
`endif
      end

      if (complete) begin
         if (out_free) begin
            q_nxt  = word;
            qv_nxt = 1'b1;
`ifdef SIPO_PARITY_EN
            perr_nxt = (^word) ^ d;
`endif
         end else begin
            ovf_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh       <= '0;
         bit_cnt  <= '0;
         q        <= '0;
         q_valid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sh       <= sh_nxt;
         bit_cnt  <= cnt_nxt;
         q        <= q_nxt;
         q_valid  <= qv_nxt;
         overflow <= ovf_nxt;
      end
   end

`ifdef SIPO_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= COLLECT;
         perr_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         perr_r <= perr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sipo_shift_reg_param.sv
// Scoreboard bench for sipo_shift_reg_param: MSB-first and LSB-first instances
// share one bit stream and are checked against a frame-level reference model.
module tb_sipo_shift_reg_param;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0, d = 1'b0, d_valid = 1'b0, clr = 1'b0, q_ready = 1'b0;
   logic [W-1:0]  q_m, q_l;
   logic          qv_m, qv_l, ovf_m, ovf_l, pe_m, pe_l;
   logic [CW-1:0] cnt_m, cnt_l;

   always #5 clk = ~clk;

   sipo_shift_reg_param #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .clr(clr),
      .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .bit_cnt(cnt_m),
      .overflow(ovf_m), .parity_err(pe_m));

   sipo_shift_reg_param #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .clr(clr),
      .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .bit_cnt(cnt_l),
      .overflow(ovf_l), .parity_err(pe_l));

   int errors = 0;
   int checks = 0;

   // Reference model: received bits of the current frame, output occupancy,
   // sticky overflow, and expected words {parity_err, lsb_word, msb_word}.
   bit           mbits[$];
   bit           mqv, movf;
   logic [2*W:0] exp_q[$];
   bit           mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r_n, input bit dd, input bit dv, input bit cl, input bit rdy);
      bit           complete = 1'b0;
      bit           load = 1'b0;
      bit           par = 1'b0;
      bit           pe = 1'b0;
      logic [W-1:0] wm = '0;
      logic [W-1:0] wl = '0;
      if (!r_n) begin
         mbits.delete();
         exp_q.delete();
         mqv  = 1'b0;
         movf = 1'b0;
         return;
      end
      if (cl) begin
         mbits.delete();
         movf = 1'b0;
      end else if (dv) begin
`ifdef SIPO_PARITY_EN
         if (mbits.size() < W) mbits.push_back(dd);
         else begin
            complete = 1'b1;
            par      = dd;
         end
`else
         mbits.push_back(dd);
         if (mbits.size() == W) complete = 1'b1;
`endif
      end
      if (complete) begin
         for (int i = 0; i < W; i++) begin
            if (mbits[i]) begin
               wm = wm + W'(1 << (W - 1 - i));
               wl = wl + W'(1 << i);
            end
         end
`ifdef SIPO_PARITY_EN
         pe = (^wm) ^ par;
`endif
         mbits.delete();
         if (!mqv || rdy) begin
            exp_q.push_back({pe, wl, wm});
            load = 1'b1;
         end else begin
            movf = 1'b1;
         end
      end
      if (mqv && rdy) mqv = 1'b0;
      if (load) mqv = 1'b1;
   endtask

   // One clock: apply inputs, let the edge happen, advance the model, settle.
   task automatic drive(input bit r_n, input bit dd, input bit dv, input bit cl, input bit rdy);
      rst_n = r_n; d = dd; d_valid = dv; clr = cl; q_ready = rdy;
      @(posedge clk);
      model_step(r_n, dd, dv, cl, rdy);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit rdy_body, input bit rdy_last);
`ifdef SIPO_PARITY_EN
      for (int i = W - 1; i >= 0; i--) drive(1'b1, w[i], 1'b1, 1'b0, rdy_body);
      drive(1'b1, ^w, 1'b1, 1'b0, rdy_last);
`else
      for (int i = W - 1; i > 0; i--) drive(1'b1, w[i], 1'b1, 1'b0, rdy_body);
      drive(1'b1, w[0], 1'b1, 1'b0, rdy_last);
`endif
   endtask

   // Monitor: compares the DUT against the model mid-cycle and consumes
   // scoreboard entries on every valid/ready handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [2*W:0] e;
         chk("bit_cnt_msb", 32'(cnt_m), 32'(mbits.size()));
         chk("bit_cnt_lsb", 32'(cnt_l), 32'(mbits.size()));
         chk("overflow_msb", 32'(ovf_m), 32'(movf));
         chk("overflow_lsb", 32'(ovf_l), 32'(movf));
         chk("q_valid_msb", 32'(qv_m), 32'(mqv));
         chk("q_valid_lsb", 32'(qv_l), 32'(mqv));
         if (qv_m) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q[0];
               chk("q_msb", 32'(q_m), 32'(e[W-1:0]));
               chk("q_lsb", 32'(q_l), 32'(e[2*W-1:W]));
               chk("parity_err_msb", 32'(pe_m), 32'(e[2*W]));
               chk("parity_err_lsb", 32'(pe_l), 32'(e[2*W]));
               if (q_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [W-1:0] pat;
      pat = 8'hA6;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_q", 32'(q_m), 32'h0);
      chk("reset_q_valid", 32'(qv_m), 32'h0);
      chk("reset_bit_cnt", 32'(cnt_m), 32'h0);
      chk("reset_overflow", 32'(ovf_m), 32'h0);
      chk("reset_parity_err", 32'(pe_m), 32'h0);
      mon_en = 1'b1;

      // Back-to-back bits, consumer always ready.
      send_word(pat, 1'b1, 1'b1);
      chk("dir_a6_msb", 32'(q_m), 32'hA6);
      chk("dir_65_lsb", 32'(q_l), 32'h65);
      chk("dir_valid_up", 32'(qv_m), 32'h1);
      chk("dir_cnt_wrap", 32'(cnt_m), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("dir_valid_one_cycle", 32'(qv_m), 32'h0);

      // Same bits with idle gaps; bit_cnt holds through them.
      for (int i = W - 1; i >= 0; i--) begin
         drive(1'b1, pat[i], 1'b1, 1'b0, 1'b1);
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         if (i == 5) chk("dir_cnt_hold_gap", 32'(cnt_m), 32'h3);
      end
`ifdef SIPO_PARITY_EN
      chk("dir_cnt_parity_phase", 32'(cnt_m), 32'h8);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("dir_parity_ok", 32'(pe_m), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = W - 1; i >= 0; i--) drive(1'b1, pat[i], 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("dir_parity_bad", 32'(pe_m), 32'h1);
`endif
      chk("dir_gap_lsb", 32'(q_l), 32'h65);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Stalled consumer: second frame dropped, overflow sticky until clr.
      send_word(8'hA6, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0);
      chk("dir_ovf_q", 32'(q_m), 32'hA6);
      chk("dir_ovf_valid", 32'(qv_m), 32'h1);
      chk("dir_ovf_set", 32'(ovf_m), 32'h1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("dir_clr_ovf", 32'(ovf_m), 32'h0);
      chk("dir_clr_q", 32'(q_m), 32'hA6);
      chk("dir_clr_valid", 32'(qv_m), 32'h1);

      // Partial frame discarded by clr; accept+load on the completing edge.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send_word(8'hFF, 1'b0, 1'b1);
      chk("dir_ff_q", 32'(q_m), 32'hFF);
      chk("dir_ff_valid", 32'(qv_m), 32'h1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset in mid-frame, then a clean frame.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("dir_rst_cnt", 32'(cnt_m), 32'h0);
      chk("dir_rst_q", 32'(q_m), 32'h0);
      chk("dir_rst_valid", 32'(qv_m), 32'h0);
      send_word(8'h5A, 1'b1, 1'b1);
      chk("dir_5a_msb", 32'(q_m), 32'h5A);
      chk("dir_5a_lsb", 32'(q_l), 32'h5A);

      // Randomized traffic against the scoreboard.
      repeat (3000) begin
         drive(($urandom % 200) != 0, 1'($urandom), ($urandom % 4) != 0,
               ($urandom % 40) == 0, 1'($urandom));
      end
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("drain_scoreboard", 32'(exp_q.size()), 32'h0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
